// File: rtl/ehgu_modulo_fifo.sv
// First-word-fall-through FIFO with non-power-of-two depth, modulo-wrapped pointers,
// binary/thermometer occupancy and a saturating producer back-pressure counter.
module ehgu_modulo_fifo #(
    parameter int unsigned DP_WIDTH        = 8,
    parameter int unsigned DEPTH           = 6,
    parameter int unsigned ALMOST_FULL_LVL = DEPTH - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DP_WIDTH-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DP_WIDTH-1:0] out_data,
    output logic [7:0]          level,
    output logic [254:0]        level_therm,
    output logic                almost_full,
    input  logic                stall_clr,
    output logic [DP_WIDTH-1:0] stall_cnt
);

    localparam int unsigned         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]          PTR_LAST  = 8'(DEPTH - 1);
    localparam logic [7:0]          LVL_FULL  = 8'(DEPTH);
    localparam logic [DP_WIDTH-1:0] STALL_MAX = '1;

    function automatic logic [7:0] modulo_inc(input logic [7:0] p);
        return (p == PTR_LAST) ? 8'd0 : p + 8'd1;
    endfunction

    function automatic logic [DP_WIDTH-1:0] saturate_inc(input logic [DP_WIDTH-1:0] x);
        return (x == STALL_MAX) ? x : x + DP_WIDTH'(1);
    endfunction

    function automatic logic [254:0] bin2therm(input logic [7:0] v);
        logic [254:0] t;
        t = '0;
        for (int unsigned i = 0; i < 255; i++) begin
            t[i] = (i < 32'(v));
        end
        return t;
    endfunction

    logic [DP_WIDTH-1:0] mem [DEPTH];
    logic [7:0]          wr_ptr;
    logic [7:0]          rd_ptr;
    logic [7:0]          level_next;
    logic                run;
    logic                push;
    logic                pop;

    // run holds in_ready low while reset is asserted without an input-to-output path
    assign in_ready  = run && (level != LVL_FULL);
    assign out_valid = (level != 8'd0);
    assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + 8'd1;
        end else if (pop && !push) begin
            level_next = level - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run         <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            level_therm <= '0;
            almost_full <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            run         <= 1'b1;
            level       <= level_next;
            level_therm <= bin2therm(level_next);
            almost_full <= (32'(level_next) >= ALMOST_FULL_LVL);
            if (push) begin
                wr_ptr <= modulo_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= modulo_inc(rd_ptr);
            end
            if (stall_clr) begin
                stall_cnt <= '0;
            end else if (in_valid && !in_ready) begin
                stall_cnt <= saturate_inc(stall_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    a_in_data_held : assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> (!in_valid || $stable(in_data)));

    a_head_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule
